// File: rtl/alice_session_ctrl_if.sv
// Signal bundle between the session controller and its user, cipher, DH engine and peer link.
// master = the session controller, slave = everything around it.
interface alice_session_ctrl_if #(
  parameter int DATA_W = 128,
  parameter int DH_W   = 64,
  parameter int CNT_W  = 32
);
  // user side
  logic              transmit_req;
  logic [DATA_W-1:0] data_in;
  logic              data_stb;
  logic              usr_long_key_ch;
  logic              session_end;
  logic              ready_for_transmit;
  logic              ready;
  logic              usr_long_key_change_rq;
  logic              kx_timeout;
  logic [CNT_W-1:0]  blocks_sent;
  // block cipher
  logic [DATA_W-1:0] cph_in;
  logic              cph_in_stb;
  logic [DATA_W-1:0] cph_key;
  logic              cph_key_valid;
  logic [DATA_W-1:0] cph_out;
  logic              cph_out_valid;
  logic              cph_ready;
  logic              cph_out_ack;
  // Diffie-Hellman engine
  logic              dh_start;
  logic [DH_W-1:0]   dh_my_key;
  logic              dh_my_key_valid;
  logic [DATA_W-1:0] dh_K;
  logic              dh_K_valid;
  // peer link
  logic [DATA_W-1:0] peer_data;
  logic              peer_data_valid;
  logic              peer_ack;

  modport master (
    input  transmit_req, data_in, data_stb, usr_long_key_ch, session_end,
           cph_out, cph_out_valid, cph_ready,
           dh_my_key, dh_my_key_valid, dh_K, dh_K_valid, peer_ack,
    output ready_for_transmit, ready, usr_long_key_change_rq, kx_timeout, blocks_sent,
           cph_in, cph_in_stb, cph_key, cph_key_valid, cph_out_ack,
           dh_start, peer_data, peer_data_valid
  );

  modport slave (
    output transmit_req, data_in, data_stb, usr_long_key_ch, session_end,
           cph_out, cph_out_valid, cph_ready,
           dh_my_key, dh_my_key_valid, dh_K, dh_K_valid, peer_ack,
    input  ready_for_transmit, ready, usr_long_key_change_rq, kx_timeout, blocks_sent,
           cph_in, cph_in_stb, cph_key, cph_key_valid, cph_out_ack,
           dh_start, peer_data, peer_data_valid
  );
endinterface

// File: rtl/alice_session_ctrl.sv
// Session controller: DH key exchange under the long key, block transfer under the
// session key, and a forced long-key change after REKEY_LIMIT delivered blocks.
module alice_session_ctrl #(
  parameter int                DATA_W           = 128,
  parameter int                DH_W             = 64,
  parameter int                CNT_W            = 32,
  parameter logic [63:0]       REKEY_LIMIT      = 64'd4294967295,
  parameter int                KX_TIMEOUT       = 1024,
  parameter logic [DATA_W-1:0] INITIAL_LONG_KEY = DATA_W'(130),
  parameter logic [DATA_W-1:0] LONG_KEY_STEP    = DATA_W'(1)
) (
  input logic                  clk,
  input logic                  reset,
  alice_session_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYGEN = 2'd1,
    XFER   = 2'd2,
    REKEY  = 2'd3
  } state_t;

  localparam int               KX_W    = $clog2(KX_TIMEOUT + 1);
  localparam logic [KX_W-1:0]  KX_LAST = KX_W'(KX_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [DATA_W-1:0] long_key;
  logic [DATA_W-1:0] session_key;
  logic [CNT_W-1:0]  blocks_sent;
  logic [KX_W-1:0]   kx_cnt;
  logic              dh_start;
  logic              rekey_rq;

  logic [DH_W-1:0]   my_key;
  logic              block_done;
  logic              limit_hit;
  logic              kx_expire;

  assign my_key     = bus.dh_my_key;
  assign block_done = (state == XFER) && bus.cph_out_valid && bus.peer_ack;
  assign limit_hit  = block_done && (64'(blocks_sent) + 64'd1 == REKEY_LIMIT);
  // An agreed key arriving in the last allowed cycle beats the timeout.
  assign kx_expire  = (state == KEYGEN) && !bus.dh_K_valid && (kx_cnt == KX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      long_key    <= INITIAL_LONG_KEY;
      session_key <= '0;
      blocks_sent <= '0;
      kx_cnt      <= '0;
      dh_start    <= 1'b0;
      rekey_rq    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch below sees the pre-edge register values.
      dh_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.transmit_req) begin
            state       <= KEYGEN;
            dh_start    <= 1'b1;
            kx_cnt      <= '0;
            blocks_sent <= '0;
          end
        end
        KEYGEN: begin
          if (bus.dh_K_valid) begin
            session_key <= bus.dh_K;
            state       <= XFER;
          end else if (kx_expire) begin
            state <= IDLE;
          end else begin
            kx_cnt <= kx_cnt + KX_W'(1);
          end
        end
        XFER: begin
          if (block_done && (blocks_sent != CNT_MAX)) blocks_sent <= blocks_sent + CNT_W'(1);
          if (limit_hit) begin
            state    <= REKEY;
            rekey_rq <= 1'b1;
          end else if (bus.session_end) begin
            state <= IDLE;
          end
        end
        REKEY: begin
          if (bus.usr_long_key_ch) begin
            long_key <= long_key + LONG_KEY_STEP;
            rekey_rq <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Cipher and peer routing follows the current state directly so handshakes stay same-cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    bus.cph_key         = '0;
    bus.cph_key_valid   = 1'b0;
    bus.cph_in          = '0;
    bus.cph_in_stb      = 1'b0;
    bus.cph_out_ack     = 1'b0;
    bus.peer_data       = '0;
    bus.peer_data_valid = 1'b0;
    case (state)
      KEYGEN: begin
        bus.cph_key         = long_key;
        bus.cph_key_valid   = 1'b1;
        bus.cph_in          = DATA_W'(my_key);
        bus.cph_in_stb      = bus.dh_my_key_valid;
        bus.cph_out_ack     = bus.dh_K_valid;
        bus.peer_data       = bus.cph_out;
        bus.peer_data_valid = bus.cph_out_valid;
      end
      XFER: begin
        bus.cph_key         = session_key;
        bus.cph_key_valid   = 1'b1;
        bus.cph_in          = bus.data_in;
        bus.cph_in_stb      = bus.data_stb && bus.cph_ready;
        bus.cph_out_ack     = bus.peer_ack && bus.cph_out_valid;
        bus.peer_data       = bus.cph_out;
        bus.peer_data_valid = bus.cph_out_valid;
      end
      default: ;
    endcase
  end

  assign bus.ready_for_transmit     = (state == IDLE);
  assign bus.ready                  = (state == XFER) && bus.cph_ready;
  assign bus.usr_long_key_change_rq = rekey_rq;
  assign bus.kx_timeout             = kx_expire;
  assign bus.blocks_sent            = blocks_sent;
  assign bus.dh_start               = dh_start;

endmodule
